// File: rtl/alu_seq_pkg.sv
// Opcode codes, FSM state encoding and helpers shared by the alu_seq execute unit.
// Optional divider: define ALU_SEQ_DIV_EN to enable opcodes 12-15.
package alu_seq_pkg;

  localparam int unsigned OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_ADD   = 4'd0;
  localparam logic [OPC_W-1:0] OP_SUB   = 4'd1;
  localparam logic [OPC_W-1:0] OP_AND   = 4'd2;
  localparam logic [OPC_W-1:0] OP_OR    = 4'd3;
  localparam logic [OPC_W-1:0] OP_XOR   = 4'd4;
  localparam logic [OPC_W-1:0] OP_SLL   = 4'd5;
  localparam logic [OPC_W-1:0] OP_SRL   = 4'd6;
  localparam logic [OPC_W-1:0] OP_SRA   = 4'd7;
  localparam logic [OPC_W-1:0] OP_MUL   = 4'd8;
  localparam logic [OPC_W-1:0] OP_MULH  = 4'd9;
  localparam logic [OPC_W-1:0] OP_MULHU = 4'd10;
  localparam logic [OPC_W-1:0] OP_DIV   = 4'd12;
  localparam logic [OPC_W-1:0] OP_DIVU  = 4'd13;
  localparam logic [OPC_W-1:0] OP_REM   = 4'd14;
  localparam logic [OPC_W-1:0] OP_REMU  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1
`ifdef ALU_SEQ_DIV_EN
    , ST_DIV = 2'd2
`endif
  } state_e;

  // Ops whose operands are treated as two's-complement before the magnitude datapath.
  function automatic logic is_signed_op(input logic [OPC_W-1:0] opc);
    return (opc == OP_MUL) || (opc == OP_MULH) || (opc == OP_DIV) || (opc == OP_REM);
  endfunction

endpackage

// File: rtl/alu_seq_div.sv
// Iterative restoring divider on unsigned magnitudes: one quotient bit per cycle.
// done_c/quo_c/rem_c present the final iteration's result combinationally.
module alu_seq_div #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done_c,
  output logic [XLEN-1:0] quo_c,
  output logic [XLEN-1:0] rem_c
);

  localparam int unsigned CW = $clog2(XLEN);

  logic            busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN:0]   rem_sh;
  logic            ge;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh = {rem_q, quo_q[XLEN-1]};
    ge     = (rem_sh >= {1'b0, dvs_q});
    quo_c  = {quo_q[XLEN-2:0], ge};
    rem_c  = ge ? XLEN'(rem_sh - {1'b0, dvs_q}) : rem_sh[XLEN-1:0];
    done_c = busy_q && (cnt_q == '0);
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = CW'(XLEN - 1);
      rem_d  = '0;
      quo_d  = dividend;
      dvs_d  = divisor;
    end else if (busy_q) begin
      rem_d = rem_c;
      quo_d = quo_c;
      cnt_d = cnt_q - CW'(1);
      if (done_c) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// RV execute unit: single-cycle ALU ops plus iterative shift-add MUL and optional divider.
// Optional divider: define ALU_SEQ_DIV_EN; otherwise opcodes 12-15 complete as ILLEGAL.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      opcode,
  input  logic [XLEN-1:0] op_0,
  input  logic [XLEN-1:0] op_1,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out,
  output logic            ZERO,
  output logic            NEGATIVE,
  output logic            ILLEGAL
);

  localparam int unsigned SHW = $clog2(XLEN);

  state_e            state_q, state_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [OPC_W-1:0]  opc_q, opc_d;
  logic              sgn0_q, sgn0_d;
  logic              sgn1_q, sgn1_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   out_q, out_d;
  logic              zero_q, zero_d;
  logic              neg_q, neg_d;
  logic              ill_q, ill_d;

  logic              accept;
  logic              signed_op;
  logic              op0_neg, op1_neg;
  logic [XLEN-1:0]   mag0, mag1;
  logic [SHW-1:0]    shamt;
  logic [XLEN-1:0]   sc_res;
  logic              sc_ill, sc_mul;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_acc_nxt, mul_prod;
  logic              res_wr, res_ill;
  logic [XLEN-1:0]   res_val;

`ifdef ALU_SEQ_DIV_EN
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic            sc_div;
  logic            div_start;
  logic            div_done_c;
  logic [XLEN-1:0] div_quo_c, div_rem_c;
  logic [XLEN-1:0] quo_fix, rem_fix;

  alu_seq_div #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (mag0),
    .divisor  (mag1),
    .done_c   (div_done_c),
    .quo_c    (div_quo_c),
    .rem_c    (div_rem_c)
  );

  assign quo_fix = (sgn0_q ^ sgn1_q) ? -div_quo_c : div_quo_c;
  assign rem_fix = sgn0_q ? -div_rem_c : div_rem_c;
`endif

  assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign shamt     = op_1[SHW-1:0];
  assign signed_op = is_signed_op(opcode);
  assign op0_neg   = signed_op && op_0[XLEN-1];
  assign op1_neg   = signed_op && op_1[XLEN-1];
  assign mag0      = op0_neg ? -op_0 : op_0;
  assign mag1      = op1_neg ? -op_1 : op_1;

  // Single-cycle results and classification of the incoming op.
  always_comb begin
    sc_res = '0;
    sc_ill = 1'b0;
    sc_mul = 1'b0;
`ifdef ALU_SEQ_DIV_EN
    sc_div = 1'b0;
`endif
    case (opcode)
      OP_ADD: sc_res = op_0 + op_1;
      OP_SUB: sc_res = op_0 - op_1;
      OP_AND: sc_res = op_0 & op_1;
      OP_OR:  sc_res = op_0 | op_1;
      OP_XOR: sc_res = op_0 ^ op_1;
      OP_SLL: sc_res = op_0 << shamt;
      OP_SRL: sc_res = op_0 >> shamt;
      OP_SRA: sc_res = XLEN'($signed(op_0) >>> shamt);
      OP_MUL, OP_MULH, OP_MULHU: sc_mul = 1'b1;
`ifdef ALU_SEQ_DIV_EN
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
        // Divide-by-zero and signed overflow bypass the iterative divider.
        if (op_1 == '0) begin
          sc_res = ((opcode == OP_DIV) || (opcode == OP_DIVU)) ? {XLEN{1'b1}} : op_0;
        end else if (signed_op && (op_0 == MIN_NEG) && (op_1 == {XLEN{1'b1}})) begin
          sc_res = (opcode == OP_DIV) ? op_0 : '0;
        end else begin
          sc_div = 1'b1;
        end
      end
`else
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: sc_ill = 1'b1;
`endif
      default: sc_ill = 1'b1;
    endcase
  end

  // Radix-2 shift-add step; the final step's product gets its sign restored.
  always_comb begin
    mul_sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
    mul_acc_nxt = {mul_sum, acc_q[XLEN-1:1]};
    mul_prod    = (sgn0_q ^ sgn1_q) ? -mul_acc_nxt : mul_acc_nxt;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    opc_d       = opc_q;
    sgn0_d      = sgn0_q;
    sgn1_d      = sgn1_q;
    out_valid_d = out_valid_q && !out_ready;
    out_d       = out_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    ill_d       = ill_q;
    res_wr      = 1'b0;
    res_val     = '0;
    res_ill     = 1'b0;
`ifdef ALU_SEQ_DIV_EN
    div_start   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          opc_d  = opcode;
          sgn0_d = op0_neg;
          sgn1_d = op1_neg;
          if (sc_mul) begin
            acc_d   = {{XLEN{1'b0}}, mag1};
            mcand_d = mag0;
            cnt_d   = SHW'(XLEN - 1);
            state_d = ST_MUL;
          end
`ifdef ALU_SEQ_DIV_EN
          else if (sc_div) begin
            div_start = 1'b1;
            state_d   = ST_DIV;
          end
`endif
          else begin
            res_wr  = 1'b1;
            res_val = sc_res;
            res_ill = sc_ill;
          end
        end
      end
      ST_MUL: begin
        acc_d = mul_acc_nxt;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == '0) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          res_wr  = 1'b1;
          res_val = (opc_q == OP_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
        end
      end
`ifdef ALU_SEQ_DIV_EN
      ST_DIV: begin
        if (div_done_c) begin
          state_d = ST_IDLE;
          res_wr  = 1'b1;
          res_val = ((opc_q == OP_DIV) || (opc_q == OP_DIVU)) ? quo_fix : rem_fix;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    if (res_wr) begin
      out_valid_d = 1'b1;
      out_d       = res_val;
      zero_d      = (res_val == '0);
      neg_d       = res_val[XLEN-1];
      ill_d       = res_ill;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      opc_q       <= '0;
      sgn0_q      <= 1'b0;
      sgn1_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      opc_q       <= opc_d;
      sgn0_q      <= sgn0_d;
      sgn1_q      <= sgn1_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      ill_q       <= ill_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign ZERO      = zero_q;
  assign NEGATIVE  = neg_q;
  assign ILLEGAL   = ill_q;

endmodule
